// File: rtl/product_accumulator.sv
// Purpose: sums bursts of 2n-bit multiplier products into an acc_w-bit result with beat count and sticky overflow.
// Latency: result is registered and valid one cycle after the in_last beat is accepted.
// Backpressure: in_ready drops while a result is held; the result is held stable until out_ready.
module product_accumulator #(
    parameter int n     = 8,
    parameter int acc_w = 2*n+8,
    parameter int cnt_w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*n-1:0]   in_product,
    input  logic             in_signed,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [acc_w-1:0] out_sum,
    output logic             out_signed,
    output logic             out_overflow,
    output logic [cnt_w-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [acc_w-1:0] acc;
    logic [cnt_w-1:0] count;
    logic             ovf;
    logic             mode;

    logic             beat;
    logic             mode_eff;
    logic [acc_w-1:0] ext;
    logic [acc_w:0]   sum_full;
    logic [acc_w-1:0] sum;
    logic             ovf_add;
    logic [cnt_w-1:0] count_nxt;

    assign in_ready = (state != HOLD);
    assign beat     = in_valid && in_ready;

    // The burst's mode is taken from the first beat and ignored afterwards.
    assign mode_eff = (state == IDLE) ? in_signed : mode;

    always_comb begin
        ext = '0;
        if (mode_eff) begin
            ext = acc_w'($signed(in_product));
        end else begin
            ext = acc_w'(in_product);
        end
    end

    assign sum_full  = {1'b0, acc} + {1'b0, ext};
    assign sum       = sum_full[acc_w-1:0];
    assign ovf_add   = mode_eff ? ((acc[acc_w-1] == ext[acc_w-1]) && (sum[acc_w-1] != acc[acc_w-1]))
                                : sum_full[acc_w];
    assign count_nxt = (count == {cnt_w{1'b1}}) ? count : count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            mode         <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_signed   <= 1'b0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        if (in_last) begin
                            out_valid    <= 1'b1;
                            out_sum      <= sum;
                            out_signed   <= mode_eff;
                            out_overflow <= ovf | ovf_add;
                            out_count    <= count_nxt;
                            // Clear on entry to HOLD so the next burst starts from zero.
                            acc          <= '0;
                            count        <= '0;
                            ovf          <= 1'b0;
                            mode         <= 1'b0;
                            state        <= HOLD;
                        end else begin
                            acc          <= sum;
                            count        <= count_nxt;
                            ovf          <= ovf | ovf_add;
                            mode         <= mode_eff;
                            state        <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with n=4, acc_w=10, cnt_w=8.
module tb_product_accumulator;

    localparam int N     = 4;
    localparam int ACC_W = 10;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_product;
    logic             in_signed;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_signed;
    logic             out_overflow;
    logic [CNT_W-1:0] out_count;

    int tests_run = 0;
    int tests_failed = 0;

    product_accumulator #(.n(N), .acc_w(ACC_W), .cnt_w(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_signed    (in_signed),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_signed   (out_signed),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat on the falling edge; it is accepted on the next rising edge.
    task automatic send(input logic [2*N-1:0] p, input logic s, input logic l);
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = p;
        in_signed  = s;
        in_last    = l;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [ACC_W-1:0] sum, input logic [CNT_W-1:0] cnt,
                              input logic ovf, input logic sgn);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"},   32'(out_sum), 32'(sum));
        chk({tag, ".count"}, 32'(out_count), 32'(cnt));
        chk({tag, ".ovf"},   32'(out_overflow), 32'(ovf));
        chk({tag, ".sgn"},   32'(out_signed), 32'(sgn));
        chk({tag, ".in_rdy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".drained_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".drained_in_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_signed  = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        #3;
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.sum",   32'(out_sum), 32'd0);
        chk("reset.count", 32'(out_count), 32'd0);
        chk("reset.ovf",   32'(out_overflow), 32'd0);
        chk("reset.sgn",   32'(out_signed), 32'd0);
        chk("reset.in_rdy", 32'(in_ready), 32'd1);
        #14;
        rst_n = 1'b1;

        // Single unsigned beat: 225
        send(8'hE1, 1'b0, 1'b1);
        chk_result("single_u", 10'd225, 8'd1, 1'b0, 1'b0);
        drain("single_u");

        // Single signed beat: -56
        send(8'hC8, 1'b1, 1'b1);
        chk_result("single_s", 10'h3C8, 8'd1, 1'b0, 1'b1);
        drain("single_s");

        // Five unsigned 225s: 1125 mod 1024 = 101, carry out
        for (int i = 0; i < 5; i++) send(8'hE1, 1'b0, i == 4);
        chk_result("five_u", 10'd101, 8'd5, 1'b1, 1'b0);
        drain("five_u");

        // Eight signed +64s: 512 wraps to -512
        for (int i = 0; i < 8; i++) send(8'h40, 1'b1, i == 7);
        chk_result("eight_s", 10'h200, 8'd8, 1'b1, 1'b1);
        drain("eight_s");

        // Mode locked by first beat: -1 + -1 = -2
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        chk_result("lock", 10'h3FE, 8'd2, 1'b0, 1'b1);
        drain("lock");

        // Gap inside a burst: 3 + 4 = 7
        send(8'h03, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        send(8'h04, 1'b0, 1'b1);
        chk_result("gap", 10'd7, 8'd2, 1'b0, 1'b0);

        // Backpressure: beats offered while held must be ignored
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = 8'h77;
        in_last    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp.valid",  32'(out_valid), 32'd1);
            chk("bp.sum",    32'(out_sum), 32'd7);
            chk("bp.count",  32'(out_count), 32'd2);
            chk("bp.in_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("bp");

        // Accumulator cleared after hold: 2 + 1 = 3
        send(8'h02, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b1);
        chk_result("after_bp", 10'd3, 8'd2, 1'b0, 1'b0);
        drain("after_bp");

        // Count saturation: 260 zero beats -> 255
        for (int i = 0; i < 260; i++) send(8'h00, 1'b0, i == 259);
        chk_result("sat", 10'd0, 8'd255, 1'b0, 1'b0);
        drain("sat");

        // Reset mid-burst clears everything asynchronously
        send(8'h10, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.valid", 32'(out_valid), 32'd0);
        chk("rst_mid.sum",   32'(out_sum), 32'd0);
        chk("rst_mid.count", 32'(out_count), 32'd0);
        chk("rst_mid.sgn",   32'(out_signed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h05, 1'b0, 1'b1);
        chk_result("post_rst", 10'd5, 8'd1, 1'b0, 1'b0);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
